// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone arbiter with a watchdog
//
// Shares one Wishbone slave (block RAM) between master 0 (instruction fetch)
// and master 1 (load/store). A grant lasts for the whole bus cycle (cyc held).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   m0_* / m1_*          master-side Wishbone ports (addr/dat/sel/cyc/stb/we in,
//                        dat/ack/err out)
//   s_*                  slave-side Wishbone port
//   grant_o              one-hot current grant (bit0 = m0, bit1 = m1), 00 when idle
module wb_arbiter_2m #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] wdog, wdog_nxt;

    logic gnt0, gnt1, active;
    logic sel_cyc, sel_stb, timeout;

    // Outputs are gated by rst so nothing leaks to the slave or masters while
    // reset is held, even before the state register has been cleared.
    assign gnt0   = (state == GNT0) && !rst;
    assign gnt1   = (state == GNT1) && !rst;
    assign active = gnt0 || gnt1;

    assign sel_cyc = gnt0 ? m0_cyc_i : (gnt1 ? m1_cyc_i : 1'b0);
    assign sel_stb = gnt0 ? m0_stb_i : (gnt1 ? m1_stb_i : 1'b0);

    // A real ack/err in the firing cycle takes priority over the watchdog.
    assign timeout = active && sel_stb && (wdog == WD_LIMIT) && !s_ack_i && !s_err_i;

    always_comb begin
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        if (gnt0) begin
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
        end else if (gnt1) begin
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
        end
    end

    assign s_cyc_o  = sel_cyc;
    assign s_stb_o  = sel_stb && !timeout;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = gnt0 && s_ack_i;
    assign m1_ack_o = gnt1 && s_ack_i;
    assign m0_err_o = gnt0 && (s_err_i || timeout);
    assign m1_err_o = gnt1 && (s_err_i || timeout);
    assign grant_o  = {gnt1, gnt0};

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counts stalled strobe cycles; any response, idle strobe or release restarts it.
    always_comb begin
        wdog_nxt = '0;
        if (active && sel_cyc && sel_stb && !s_ack_i && !s_err_i && !timeout) begin
            wdog_nxt = wdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - scoreboard bench for wb_arbiter_2m
module tb_wb_arbiter_2m;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr [2];
    logic [31:0] m_dat  [2];
    logic [3:0]  m_sel  [2];
    logic        m_cyc  [2];
    logic        m_stb  [2];
    logic        m_we   [2];
    logic [31:0] m0_dat_o, m1_dat_o, s_addr_o, s_dat_o, s_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [3:0]  s_sel_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
    logic [1:0]  grant_o;

    wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m_addr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_addr_i(m_addr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [70:0] s;   // {addr, dat, sel, cyc, stb, we}
        logic [33:0] m0;  // {dat, ack, err}
        logic [33:0] m1;
        logic [1:0]  g;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: who owns the bus, who had it last, stalled-strobe count.
    int   owner, last_m, wd;
    int   ack_mode, ack_pct;
    bit   exp_to, exp_live;
    logic [31:0] ram [64];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("slave_bus", {s_addr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o}, e.s);
            chk("m0_resp", {m0_dat_o, m0_ack_o, m0_err_o}, e.m0);
            chk("m1_resp", {m1_dat_o, m1_ack_o, m1_err_o}, e.m1);
            chk("grant", grant_o, e.g);
        end
    end

    // Drive the slave response for this cycle, queue the expectation, reach the negedge.
    task automatic half();
        exp_t e;
        int   oi;
        bit   to;
        oi = (owner < 0) ? 0 : owner;
        exp_live = !rst && owner >= 0 && m_stb[oi];
        case (ack_mode)
            0: begin s_ack_i = 1'b0; s_err_i = 1'b0; end
            1: begin s_ack_i = exp_live; s_err_i = 1'b0; end
            3: begin s_ack_i = exp_live && (wd == T - 1); s_err_i = 1'b0; end
            default: begin
                s_ack_i = ($urandom_range(99) < ack_pct);
                s_err_i = !s_ack_i && ($urandom_range(15) == 0);
            end
        endcase
        s_dat_i = (exp_live && !m_we[oi]) ? ram[m_addr[oi][7:2]] : $urandom;
        e = '0;
        e.m0[33:2] = s_dat_i;
        e.m1[33:2] = s_dat_i;
        to = 1'b0;
        if (!rst && owner >= 0) begin
            to = m_stb[oi] && (wd == T - 1) && !s_ack_i && !s_err_i;
            e.s = {m_addr[oi], m_dat[oi], m_sel[oi], m_cyc[oi], m_stb[oi] && !to, m_we[oi]};
            if (owner == 0) begin
                e.m0[1:0] = {s_ack_i, s_err_i || to};
                e.g = 2'b01;
            end else begin
                e.m1[1:0] = {s_ack_i, s_err_i || to};
                e.g = 2'b10;
            end
        end
        exp_to = to;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic adv();
        int oi;
        @(posedge clk);
        oi = (owner < 0) ? 0 : owner;
        if (exp_live && s_ack_i && m_we[oi]) begin
            for (int b = 0; b < 4; b++)
                if (m_sel[oi][b]) ram[m_addr[oi][7:2]][8*b +: 8] = m_dat[oi][8*b +: 8];
        end
        if (rst) begin
            owner = -1; last_m = 1; wd = 0;
        end else if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) owner = (last_m == 1) ? 0 : 1;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
        end else if (!m_cyc[oi]) begin
            last_m = owner; owner = -1; wd = 0;
        end else if (m_stb[oi] && !s_ack_i && !s_err_i && !exp_to) begin
            wd++;
        end else begin
            wd = 0;
        end
        #1;
    endtask

    task automatic step();
        half();
        adv();
    endtask

    task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] addr, input logic [31:0] dat);
        m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
        m_addr[i] = addr; m_dat[i] = dat; m_sel[i] = 4'hF;
    endtask

    task automatic idle_both();
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = i * 32'h01010101;
        ram[0] = 32'h00001297;
        owner = -1; last_m = 1; wd = 0; ack_mode = 1; ack_pct = 50;
        rst = 1'b1; s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;

        // reset
        half();
        chk("reset_grant", grant_o, 2'b00);
        chk("reset_s_cyc", s_cyc_o, 1'b0);
        adv();
        step();
        rst = 1'b0;

        // m0 single read of address 0
        set_m(0, 1, 1, 0, 32'h0, 32'h0);
        half(); chk("t1_req_grant", grant_o, 2'b00); adv();
        half();
        chk("t1_grant", grant_o, 2'b01);
        chk("t1_m0_ack", m0_ack_o, 1'b1);
        chk("t1_m0_dat", m0_dat_o, 32'h00001297);
        chk("t1_m1_ack", m1_ack_o, 1'b0);
        adv();
        idle_both();

        // tie after reset: m0 first, then m1 after one idle cycle, then m0 again
        rst = 1'b1; step(); rst = 1'b0;
        set_m(0, 1, 1, 0, 32'h4, 32'h0);
        set_m(1, 1, 1, 0, 32'h8, 32'h0);
        half(); chk("t2_idle", grant_o, 2'b00); adv();
        half(); chk("t2_first", grant_o, 2'b01); adv();
        step();
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        half(); chk("t2_release", grant_o, 2'b01); adv();
        half(); chk("t2_gap", grant_o, 2'b00); adv();
        half(); chk("t2_second", grant_o, 2'b10); adv();
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();
        set_m(0, 1, 1, 0, 32'h4, 32'h0);
        set_m(1, 1, 1, 0, 32'h8, 32'h0);
        half(); adv();
        half(); chk("t2_tie_again", grant_o, 2'b01); adv();
        idle_both();

        // m1 holds the cycle across three strobes while m0 waits
        set_m(1, 1, 1, 1, 32'h10, 32'hCAFEF00D);
        set_m(0, 1, 1, 0, 32'h0, 32'h0);
        half(); chk("t3_idle", grant_o, 2'b00); adv();
        half(); chk("t3_sw_grant", grant_o, 2'b10); chk("t3_sw_ack", m1_ack_o, 1'b1); adv();
        set_m(1, 1, 1, 0, 32'h10, 32'h0);
        half();
        chk("t3_lw0_grant", grant_o, 2'b10);
        chk("t3_lw0_dat", m1_dat_o, 32'hCAFEF00D);
        chk("t3_m0_ack", m0_ack_o, 1'b0);
        adv();
        set_m(1, 1, 1, 0, 32'h14, 32'h0);
        half(); chk("t3_lw1_grant", grant_o, 2'b10); chk("t3_lw1_dat", m1_dat_o, 32'h05050505); adv();
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        half(); chk("t3_release", grant_o, 2'b10); adv();
        half(); chk("t3_gap", grant_o, 2'b00); adv();
        half(); chk("t3_m0_after", grant_o, 2'b01); adv();
        idle_both();

        // watchdog: slave never responds
        ack_mode = 0;
        set_m(0, 1, 1, 0, 32'h20, 32'h0);
        half(); adv();
        for (int k = 0; k < 10; k++) begin
            half();
            chk("t4_err", m0_err_o, k == 7);
            chk("t4_stb", s_stb_o, k != 7);
            chk("t4_grant", grant_o, 2'b01);
            adv();
        end
        idle_both();

        // ack arrives in the cycle the watchdog would fire
        ack_mode = 3;
        set_m(0, 1, 1, 0, 32'h24, 32'h0);
        half(); adv();
        for (int k = 0; k < 8; k++) begin
            half();
            chk("t5_ack", m0_ack_o, k == 7);
            chk("t5_err", m0_err_o, 1'b0);
            adv();
        end
        ack_mode = 1;
        idle_both();

        // reset in the middle of an m1 transfer
        ack_mode = 0;
        set_m(1, 1, 1, 0, 32'h30, 32'h0);
        half(); adv();
        step();
        half(); chk("t6_pre", grant_o, 2'b10); adv();
        rst = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        half(); chk("t6_in_rst_ack", m1_ack_o, 1'b0); adv();
        rst = 1'b0;
        half();
        chk("t6_grant", grant_o, 2'b00);
        chk("t6_s_cyc", s_cyc_o, 1'b0);
        chk("t6_m1_ack", m1_ack_o, 1'b0);
        adv();
        half(); chk("t6_after_rst", grant_o, 2'b01); adv();
        ack_mode = 1;
        idle_both();

        // randomized traffic against the model
        ack_mode = 2;
        for (int c = 0; c < 900; c++) begin
            if (c % 60 == 0) begin
                case ($urandom_range(2))
                    0: ack_pct = 0;
                    1: ack_pct = 30;
                    default: ack_pct = 80;
                endcase
            end
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(11) == 0) m_cyc[i] = !m_cyc[i];
                m_stb[i]  = m_cyc[i] && ($urandom_range(15) != 0);
                m_we[i]   = $urandom_range(1) == 1;
                m_addr[i] = {24'h0, 6'($urandom_range(63)), 2'b00};
                m_dat[i]  = $urandom;
                m_sel[i]  = 4'($urandom_range(14) + 1);
            end
            rst = ($urandom_range(96) == 0);
            step();
        end
        rst = 1'b0;
        ack_mode = 1;
        idle_both();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
